cdr_strobe_gen: RTL and testbench

//  Parametrised symbol-period counter for the CDR loop. Generates N_TAPS programmable

---
 rtl/cdr_strobe_gen_pkg.sv | 14 +
 rtl/cdr_strobe_gen_if.sv | 29 ++
 rtl/cdr_strobe_gen_lock_mon.sv | 32 +++
 rtl/cdr_strobe_gen.sv | 97 +++++++++
 tb/tb_cdr_strobe_gen.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/cdr_strobe_gen_pkg.sv
// Shared widths, tap indices and limits for the CDR strobe generator.
// Pure declarations; no logic, no latency, no backpressure.
package cdr_pkg;
    localparam int CNT_W            = 6;
    localparam int N_TAPS_DEF       = 3;
    localparam int LOCK_PERIODS_DEF = 8;
    localparam int MIN_PERIOD       = 2;

    localparam int TAP_EARLY = 0;
    localparam int TAP_MID   = 1;
    localparam int TAP_LATE  = 2;

    typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/cdr_strobe_gen_if.sv
// Configuration, slip requests and strobe outputs of the CDR strobe generator.
// Plain wires; no latency, no backpressure (strobes are fire-and-forget pulses).
interface cdr_strobe_gen_if #(
    parameter int CNT_W  = cdr_pkg::CNT_W,
    parameter int N_TAPS = cdr_pkg::N_TAPS_DEF
);
    logic                      i_enable;
    logic                      i_tick;
    logic [CNT_W-1:0]          i_period;
    logic [N_TAPS*CNT_W-1:0]   i_tap_off;
    logic [CNT_W-1:0]          i_pd_off;
    logic                      i_adv;
    logic                      i_ret;
    logic [N_TAPS-1:0]         o_tap_en;
    logic                      o_pd_en;
    logic                      o_boundary;
    logic [CNT_W-1:0]          o_period_act;
    logic                      o_locked;

    modport master (
        output i_enable, i_tick, i_period, i_tap_off, i_pd_off, i_adv, i_ret,
        input  o_tap_en, o_pd_en, o_boundary, o_period_act, o_locked
    );

    modport slave (
        input  i_enable, i_tick, i_period, i_tap_off, i_pd_off, i_adv, i_ret,
        output o_tap_en, o_pd_en, o_boundary, o_period_act, o_locked
    );
endinterface

// File: rtl/cdr_strobe_gen_lock_mon.sv
// Saturating count of slip-free period wraps; o_locked once LOCK_PERIODS reached.
// Latency: o_locked updates the clock after a wrap; no backpressure.
module cdr_lock_mon #(
    parameter int LOCK_PERIODS = cdr_pkg::LOCK_PERIODS_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_wrap,
    input  logic i_slip,
    output logic o_locked
);
    import cdr_pkg::*;

    localparam int              LC_W   = $clog2(LOCK_PERIODS + 1);
    localparam logic [LC_W-1:0] LC_MAX = LC_W'(LOCK_PERIODS);

    logic [LC_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_wrap) begin
            if (i_slip)
                r_cnt <= '0;
            else if (r_cnt < LC_MAX)
                r_cnt <= r_cnt + LC_W'(1);
        end
    end

    assign o_locked = (r_cnt >= LC_MAX);
endmodule

// File: rtl/cdr_strobe_gen.sv
// Symbol-period counter producing tap strobes, PD enable and boundary pulse with slip/lock.
// Latency: all strobes one clock after the tick that matches; no backpressure.
module cdr_strobe_gen #(
    parameter int CNT_W        = cdr_pkg::CNT_W,
    parameter int N_TAPS       = cdr_pkg::N_TAPS_DEF,
    parameter int LOCK_PERIODS = cdr_pkg::LOCK_PERIODS_DEF
) (
    input logic             i_clk,
    input logic             i_rst,
    cdr_strobe_gen_if.slave bus
);
    import cdr_pkg::*;

    localparam logic [CNT_W-1:0] PERIOD_MIN = CNT_W'(MIN_PERIOD);

    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_period_act;
    logic              r_adv_pend;
    logic              r_ret_pend;
    logic              r_ret_hold;
    logic              r_boundary;
    logic              r_pd_en;
    logic [N_TAPS-1:0] r_tap_en;

    logic [CNT_W-1:0]  w_period_clamped;
    logic [CNT_W-1:0]  w_term_cnt;
    logic [N_TAPS-1:0] w_tap_hit;
    logic              w_clear;
    logic              w_term;
    logic              w_eff_adv;
    logic              w_eff_ret;
    logic              w_decide;
    logic              w_hold_start;
    logic              w_wrap;
    logic              w_slip;
    logic              w_strobe_ok;

    assign w_clear          = !i_rst || !bus.i_enable;
    assign w_period_clamped = (bus.i_period < PERIOD_MIN) ? PERIOD_MIN : bus.i_period;
    assign w_term_cnt       = r_period_act - CNT_W'(1);
    assign w_term           = (r_cnt == w_term_cnt);
    // Opposite requests cancel each other at the wrap.
    assign w_eff_adv        = r_adv_pend & ~r_ret_pend;
    assign w_eff_ret        = r_ret_pend & ~r_adv_pend;
    // The first terminal tick decides the slip; a retard then stays on terminal one more tick.
    assign w_decide         = bus.i_tick & w_term & ~r_ret_hold;
    assign w_hold_start     = w_decide & w_eff_ret;
    assign w_wrap           = bus.i_tick & w_term & (r_ret_hold | ~w_eff_ret);
    assign w_slip           = w_wrap & (r_ret_hold | w_eff_adv);
    assign w_strobe_ok      = bus.i_tick & ~r_ret_hold;

    for (genvar k = 0; k < N_TAPS; k++) begin : g_tap
        assign w_tap_hit[k] = (r_cnt == bus.i_tap_off[k*CNT_W +: CNT_W]);
    end

    always_ff @(posedge i_clk) begin
        if (w_clear) begin
            r_cnt        <= '0;
            r_period_act <= w_period_clamped;
            r_adv_pend   <= 1'b0;
            r_ret_pend   <= 1'b0;
            r_ret_hold   <= 1'b0;
            r_boundary   <= 1'b0;
            r_pd_en      <= 1'b0;
            r_tap_en     <= '0;
        end else begin
            r_adv_pend <= (r_adv_pend & ~w_decide) | bus.i_adv;
            r_ret_pend <= (r_ret_pend & ~w_decide) | bus.i_ret;
            r_ret_hold <= w_hold_start | (r_ret_hold & ~w_wrap);
            r_boundary <= w_wrap;
            r_pd_en    <= w_strobe_ok & (r_cnt == bus.i_pd_off);
            r_tap_en   <= w_tap_hit & {N_TAPS{w_strobe_ok}};
            if (w_wrap) begin
                r_cnt        <= (w_eff_adv & ~r_ret_hold) ? CNT_W'(1) : '0;
                r_period_act <= w_period_clamped;
            end else if (bus.i_tick && !w_term) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    cdr_lock_mon #(
        .LOCK_PERIODS (LOCK_PERIODS)
    ) u_lock_mon (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clr    (!bus.i_enable),
        .i_wrap   (w_wrap),
        .i_slip   (w_slip),
        .o_locked (bus.o_locked)
    );

    assign bus.o_tap_en     = r_tap_en;
    assign bus.o_pd_en      = r_pd_en;
    assign bus.o_boundary   = r_boundary;
    assign bus.o_period_act = r_period_act;
endmodule

// File: tb/tb_cdr_strobe_gen.sv
// Directed bench for cdr_strobe_gen; pulse positions are logged per clock and
// compared against hand-computed clock indices (tick every 4th clock).
module tb_cdr_strobe_gen;
    import cdr_pkg::*;

    logic tb_clk;
    logic tb_rst;

    cdr_strobe_gen_if bus ();

    cdr_strobe_gen dut (
        .i_clk (tb_clk),
        .i_rst (tb_rst),
        .bus   (bus)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    int n;
    int ph;
    int n_cmp;
    int n_fail;
    int n0;
    bit tick_run;
    int q_bnd[$];
    int q_t0[$];
    int q_t1[$];
    int q_t2[$];
    int q_pd[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int qat(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic clear_q();
        q_bnd.delete();
        q_t0.delete();
        q_t1.delete();
        q_t2.delete();
        q_pd.delete();
    endtask

    // One clock: drive tick, advance, then log every pulse seen after the edge.
    task automatic cyc();
        bus.i_tick = tick_run && (ph == 0);
        @(posedge tb_clk);
        #1;
        n++;
        ph = (ph + 1) % 4;
        if (bus.o_boundary === 1'b1)          q_bnd.push_back(n);
        if (bus.o_tap_en[TAP_EARLY] === 1'b1) q_t0.push_back(n);
        if (bus.o_tap_en[TAP_MID] === 1'b1)   q_t1.push_back(n);
        if (bus.o_tap_en[TAP_LATE] === 1'b1)  q_t2.push_back(n);
        if (bus.o_pd_en === 1'b1)             q_pd.push_back(n);
    endtask

    task automatic run_to(input int target);
        while (n < target) cyc();
    endtask

    initial begin
        n = 0; ph = 0; n_cmp = 0; n_fail = 0; n0 = 0; tick_run = 1'b0;
        tb_rst        = 1'b0;
        bus.i_enable  = 1'b1;
        bus.i_tick    = 1'b0;
        bus.i_period  = cnt_t'(24);
        bus.i_tap_off = {cnt_t'(20), cnt_t'(11), cnt_t'(1)};
        bus.i_pd_off  = cnt_t'(21);
        bus.i_adv     = 1'b0;
        bus.i_ret     = 1'b0;

        // Reset state
        repeat (3) cyc();
        chk("rst_tap", 32'(bus.o_tap_en), 0);
        chk("rst_pd", 32'(bus.o_pd_en), 0);
        chk("rst_bnd", 32'(bus.o_boundary), 0);
        chk("rst_lock", 32'(bus.o_locked), 0);
        chk("rst_period", 32'(bus.o_period_act), 24);

        // Period 24, one strobe of each kind per 96 clocks
        tb_rst = 1'b1; n = 0; ph = 0; tick_run = 1'b1;
        clear_q();
        run_to(200);
        chk("t1_bnd_first", qat(q_bnd, 0), 93);
        chk("t1_bnd_second", qat(q_bnd, 1), 189);
        chk("t1_bnd_count", q_bnd.size(), 2);
        chk("t1_early_first", qat(q_t0, 0), 5);
        chk("t1_early_count", q_t0.size(), 3);
        chk("t1_mid_first", qat(q_t1, 0), 45);
        chk("t1_mid_count", q_t1.size(), 2);
        chk("t1_late_first", qat(q_t2, 0), 81);
        chk("t1_pd_first", qat(q_pd, 0), 85);
        chk("t1_pd_second", qat(q_pd, 1), 181);

        // Shadowed period change
        clear_q();
        bus.i_period = cnt_t'(20);
        run_to(284);
        chk("t2_period_hold", 32'(bus.o_period_act), 24);
        cyc();
        chk("t2_period_new", 32'(bus.o_period_act), 20);
        chk("t2_bnd_at_wrap", 32'(bus.o_boundary), 1);
        run_to(300);
        bus.i_period = cnt_t'(24);
        run_to(470);
        chk("t2_bnd_a", qat(q_bnd, 0), 285);
        chk("t2_bnd_b", qat(q_bnd, 1), 365);
        chk("t2_bnd_c", qat(q_bnd, 2), 461);

        // Advance: next period 23 ticks
        clear_q();
        run_to(482);
        bus.i_adv = 1'b1; cyc(); bus.i_adv = 1'b0;
        run_to(655);
        chk("t3_adv_wrap", qat(q_bnd, 0), 557);
        chk("t3_adv_short", qat(q_bnd, 1), 649);

        // Retard: next period 25 ticks, single boundary pulse
        clear_q();
        bus.i_ret = 1'b1; cyc(); bus.i_ret = 1'b0;
        run_to(755);
        chk("t3_ret_count", q_bnd.size(), 1);
        chk("t3_ret_long", qat(q_bnd, 0), 749);

        // Advance and retard together cancel
        clear_q();
        run_to(760);
        bus.i_adv = 1'b1; bus.i_ret = 1'b1; cyc();
        bus.i_adv = 1'b0; bus.i_ret = 1'b0;
        run_to(950);
        chk("t3_cancel_a", qat(q_bnd, 0), 845);
        chk("t3_cancel_b", qat(q_bnd, 1), 941);

        // Lock after 8 slip-free wraps, drop after a slip wrap
        run_to(1516);
        chk("t4_lock_pre", 32'(bus.o_locked), 0);
        cyc();
        chk("t4_lock_on", 32'(bus.o_locked), 1);
        run_to(1530);
        bus.i_adv = 1'b1; cyc(); bus.i_adv = 1'b0;
        run_to(1612);
        chk("t4_lock_hold", 32'(bus.o_locked), 1);
        cyc();
        chk("t4_lock_drop", 32'(bus.o_locked), 0);
        chk("t4_slip_bnd", 32'(bus.o_boundary), 1);
        run_to(2376);
        chk("t4_relock_pre", 32'(bus.o_locked), 0);
        cyc();
        chk("t4_relock", 32'(bus.o_locked), 1);

        // Enable drop mid-period clears everything, including a pending advance
        run_to(2390);
        bus.i_adv = 1'b1; cyc(); bus.i_adv = 1'b0;
        run_to(2400);
        bus.i_enable = 1'b0;
        bus.i_period = cnt_t'(16);
        cyc();
        chk("t6_dis_tap", 32'(bus.o_tap_en), 0);
        chk("t6_dis_pd", 32'(bus.o_pd_en), 0);
        chk("t6_dis_bnd", 32'(bus.o_boundary), 0);
        chk("t6_dis_lock", 32'(bus.o_locked), 0);
        chk("t6_dis_track16", 32'(bus.o_period_act), 16);
        bus.i_period = cnt_t'(24);
        cyc();
        chk("t6_dis_track24", 32'(bus.o_period_act), 24);
        clear_q();
        bus.i_enable = 1'b1; ph = 0; n0 = n;
        run_to(n0 + 100);
        chk("t6_en_bnd_count", q_bnd.size(), 1);
        chk("t6_en_bnd_full", qat(q_bnd, 0), n0 + 93);
        chk("t6_en_early", qat(q_t0, 0), n0 + 5);

        // Reset mid-period with a pending retard; then clamped period 1 -> 2
        bus.i_period  = cnt_t'(1);
        bus.i_tap_off = {cnt_t'(1), cnt_t'(1), cnt_t'(30)};
        bus.i_pd_off  = cnt_t'(0);
        run_to(n0 + 108);
        bus.i_ret = 1'b1; cyc(); bus.i_ret = 1'b0;
        run_to(n0 + 118);
        tb_rst = 1'b0;
        cyc();
        chk("t6_rst_tap", 32'(bus.o_tap_en), 0);
        chk("t6_rst_bnd", 32'(bus.o_boundary), 0);
        chk("t6_rst_lock", 32'(bus.o_locked), 0);
        chk("t5_rst_clamp", 32'(bus.o_period_act), 2);
        clear_q();
        tb_rst = 1'b1; ph = 0; n0 = n;
        run_to(n0 + 40);
        chk("t5_period_clamp", 32'(bus.o_period_act), 2);
        chk("t5_tap30_never", q_t0.size(), 0);
        chk("t5_bnd_first", qat(q_bnd, 0), n0 + 5);
        chk("t5_bnd_count", q_bnd.size(), 5);
        chk("t5_mid_first", qat(q_t1, 0), n0 + 5);
        chk("t5_late_first", qat(q_t2, 0), n0 + 5);
        chk("t5_mid_count", q_t1.size(), 5);
        chk("t5_late_count", q_t2.size(), 5);
        chk("t5_pd_first", qat(q_pd, 0), n0 + 1);
        chk("t5_pd_count", q_pd.size(), 5);
        chk("t5_no_x", 32'($isunknown({bus.o_tap_en, bus.o_pd_en, bus.o_boundary,
                                       bus.o_period_act, bus.o_locked})), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
